// File: rtl/romc_pair_sequencer.sv
// Burst sequencer for the dual-port ROM C pair-sum datapath: issues address pairs,
// phases the datapath enable, tags/indexes each pair sum and accumulates the burst total.
module romc_pair_sequencer #(
  parameter int ADDR_W  = 7,
  parameter int RES_W   = 17,
  parameter int ACC_W   = 24,
  parameter int ENA_DLY = 1,
  parameter int LAT     = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] pair_cnt,
  output logic [ADDR_W-1:0] adrC,
  output logic [ADDR_W-1:0] adrCnext,
  output logic              ena,
  input  logic [RES_W-1:0]  result,
  output logic              busy,
  output logic              res_valid,
  output logic [5:0]        res_idx,
  output logic [ACC_W-1:0]  acc_sum,
  output logic              done
);

  localparam int IDX_W     = 6;
  localparam int MAX_PAIRS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      state_r;
  logic                        iss_vld_r;
  logic [IDX_W-1:0]            iss_idx_r;
  logic [IDX_W-1:0]            last_idx_r;
  logic [ENA_DLY-1:0]          ena_sr_r;
  logic [LAT-1:0]              vld_sr_r;
  logic [LAT-1:0][IDX_W-1:0]   idx_sr_r;

  logic [ADDR_W-1:0]           sat_cnt_s;
  logic [IDX_W-1:0]            last_idx_s;
  logic                        drain_last_s;

  // Burst length saturation and detection of the final result leaving the pipeline.
  always_comb begin
    sat_cnt_s    = (pair_cnt > ADDR_W'(MAX_PAIRS)) ? ADDR_W'(MAX_PAIRS) : pair_cnt;
    last_idx_s   = IDX_W'(sat_cnt_s - ADDR_W'(1));
    drain_last_s = vld_sr_r[LAT-1] & ~(|vld_sr_r[LAT-2:0]);
  end

  // The output ports are the tail stages of the delay lines, so they stay registered.
  assign ena       = ena_sr_r[ENA_DLY-1];
  assign res_valid = vld_sr_r[LAT-1];
  assign res_idx   = idx_sr_r[LAT-1];

  // Sequencer FSM, address generation, enable/valid/index delay lines and accumulator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      iss_vld_r  <= 1'b0;
      iss_idx_r  <= '0;
      last_idx_r <= '0;
      ena_sr_r   <= '0;
      vld_sr_r   <= '0;
      idx_sr_r   <= '0;
      adrC       <= '0;
      adrCnext   <= '0;
      busy       <= 1'b0;
      acc_sum    <= '0;
      done       <= 1'b0;
    end else if (abort && (state_r != ST_IDLE)) begin
      // Partial acc_sum and the last addresses are deliberately left untouched.
      state_r   <= ST_IDLE;
      iss_vld_r <= 1'b0;
      ena_sr_r  <= '0;
      vld_sr_r  <= '0;
      idx_sr_r  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done        <= 1'b0;
      ena_sr_r[0] <= iss_vld_r;
      for (int k = 1; k < ENA_DLY; k++) begin
        ena_sr_r[k] <= ena_sr_r[k-1];
      end
      vld_sr_r[0] <= iss_vld_r;
      idx_sr_r[0] <= iss_vld_r ? iss_idx_r : IDX_W'(0);
      for (int k = 1; k < LAT; k++) begin
        vld_sr_r[k] <= vld_sr_r[k-1];
        idx_sr_r[k] <= idx_sr_r[k-1];
      end
      if (vld_sr_r[LAT-1]) begin
        acc_sum <= acc_sum + ACC_W'(result);
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            acc_sum <= '0;
            busy    <= 1'b1;
            if (sat_cnt_s != ADDR_W'(0)) begin
              state_r    <= ST_ISSUE;
              iss_vld_r  <= 1'b1;
              iss_idx_r  <= '0;
              last_idx_r <= last_idx_s;
              adrC       <= base_addr;
              adrCnext   <= base_addr + ADDR_W'(1);
            end else begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (iss_idx_r == last_idx_r) begin
            state_r   <= ST_DRAIN;
            iss_vld_r <= 1'b0;
          end else begin
            iss_idx_r <= iss_idx_r + IDX_W'(1);
            adrC      <= adrC + ADDR_W'(2);
            adrCnext  <= adrCnext + ADDR_W'(2);
          end
        end
        ST_DRAIN: begin
          if (drain_last_s) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          iss_vld_r <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_romc_pair_sequencer.sv
// Directed bench for romc_pair_sequencer with a behavioural ROM C datapath (mem[i]=i).
module tb_romc_pair_sequencer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [6:0]  base_addr;
  logic [6:0]  pair_cnt;
  logic [6:0]  adrC;
  logic [6:0]  adrCnext;
  logic        ena;
  logic [16:0] result;
  logic        busy;
  logic        res_valid;
  logic [5:0]  res_idx;
  logic [23:0] acc_sum;
  logic        done;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] rom_mem [128];
  logic [15:0] rd_a = 16'd0, rd_b = 16'd0, reg_a = 16'd0, reg_b = 16'd0;

  romc_pair_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .base_addr(base_addr), .pair_cnt(pair_cnt),
    .adrC(adrC), .adrCnext(adrCnext), .ena(ena), .result(result),
    .busy(busy), .res_valid(res_valid), .res_idx(res_idx),
    .acc_sum(acc_sum), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 16'(i);
    result = 17'd0;
  end

  // Datapath: ROM read, enable-gated register stage, pair-sum output register.
  always @(posedge clk) begin
    rd_a   <= rom_mem[adrC];
    rd_b   <= rom_mem[adrCnext];
    reg_a  <= ena ? rd_a : 16'd0;
    reg_b  <= ena ? rd_b : 16'd0;
    result <= {1'b0, reg_a} + {1'b0, reg_b};
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, " busy"}, 32'(busy), 32'd0);
    check_val({tag, " ena"}, 32'(ena), 32'd0);
    check_val({tag, " res_valid"}, 32'(res_valid), 32'd0);
    check_val({tag, " res_idx"}, 32'(res_idx), 32'd0);
    check_val({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Full burst with per-cycle expectations; k counts cycles from the first address.
  task automatic run_burst(input logic [6:0] b, input logic [6:0] pc, input int exp_sum,
                           input bit drain_start);
    int n;
    int a;
    bit v;
    n = (pc > 7'd64) ? 64 : int'(pc);
    base_addr = b;
    pair_cnt  = pc;
    start     = 1'b1;
    step();
    start = 1'b0;
    if (n == 0) begin
      check_val("empty done", 32'(done), 32'd1);
      check_val("empty busy", 32'(busy), 32'd1);
      check_val("empty ena", 32'(ena), 32'd0);
      check_val("empty acc", 32'(acc_sum), 32'd0);
      step();
      check_val("empty done end", 32'(done), 32'd0);
      check_val("empty busy end", 32'(busy), 32'd0);
      check_val("empty ena end", 32'(ena), 32'd0);
    end else begin
      for (int k = 0; k <= n + 3; k++) begin
        if (k < n) begin
          check_val($sformatf("adrC b%0d k%0d", b, k), 32'(adrC), 32'((int'(b) + 2 * k) % 128));
          check_val($sformatf("adrCnext b%0d k%0d", b, k), 32'(adrCnext),
                    32'((int'(b) + 2 * k + 1) % 128));
        end
        check_val($sformatf("ena b%0d k%0d", b, k), 32'(ena), 32'(k >= 1 && k <= n));
        v = (k >= 3) && (k < n + 3);
        check_val($sformatf("res_valid b%0d k%0d", b, k), 32'(res_valid), 32'(v));
        check_val($sformatf("res_idx b%0d k%0d", b, k), 32'(res_idx), v ? 32'(k - 3) : 32'd0);
        if (v) begin
          a = (int'(b) + 2 * (k - 3)) % 128;
          check_val($sformatf("result b%0d k%0d", b, k), 32'(result), 32'(a + (a + 1) % 128));
        end
        check_val($sformatf("done b%0d k%0d", b, k), 32'(done), 32'(k == n + 3));
        check_val($sformatf("busy b%0d k%0d", b, k), 32'(busy), 32'd1);
        if (k <= 3) check_val($sformatf("acc clear b%0d k%0d", b, k), 32'(acc_sum), 32'd0);
        if (k == n + 3) check_val($sformatf("acc final b%0d", b), 32'(acc_sum), 32'(exp_sum));
        if (drain_start && k == n + 1) begin
          start     = 1'b1;
          base_addr = 7'd40;
          pair_cnt  = 7'd5;
        end else begin
          start = 1'b0;
        end
        step();
      end
      start = 1'b0;
      check_val($sformatf("done end b%0d", b), 32'(done), 32'd0);
      check_val($sformatf("busy end b%0d", b), 32'(busy), 32'd0);
      check_val($sformatf("ena end b%0d", b), 32'(ena), 32'd0);
      check_val($sformatf("acc hold b%0d", b), 32'(acc_sum), 32'(exp_sum));
    end
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = 7'd0;
    pair_cnt  = 7'd0;
    step();
    step();
    check_val("rst adrC", 32'(adrC), 32'd0);
    check_val("rst adrCnext", 32'(adrCnext), 32'd0);
    check_val("rst acc", 32'(acc_sum), 32'd0);
    check_quiet("rst");
    resetn = 1'b1;
    step();

    // Asynchronous reset in the middle of an 8-pair burst at base 10.
    base_addr = 7'd10;
    pair_cnt  = 7'd8;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_val("pre-rst adrC", 32'(adrC), 32'd14);
    check_val("pre-rst ena", 32'(ena), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_val("mid-rst adrC", 32'(adrC), 32'd0);
    check_val("mid-rst adrCnext", 32'(adrCnext), 32'd0);
    check_val("mid-rst acc", 32'(acc_sum), 32'd0);
    check_quiet("mid-rst");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_quiet($sformatf("post-rst c%0d", i));
    end

    // Ordinary burst with an ignored start in DRAIN, then a back-to-back wrap burst.
    run_burst(7'd0, 7'd4, 28, 1'b1);
    run_burst(7'd126, 7'd2, 254, 1'b0);
    run_burst(7'd0, 7'd0, 0, 1'b0);
    run_burst(7'd0, 7'd100, 8128, 1'b0);

    // Abort during the second issued pair of an 8-pair burst.
    base_addr = 7'd0;
    pair_cnt  = 7'd8;
    start     = 1'b1;
    step();
    start = 1'b0;
    check_val("abort k0 adrC", 32'(adrC), 32'd0);
    step();
    check_val("abort k1 adrC", 32'(adrC), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_quiet("abort");
    check_val("abort acc", 32'(acc_sum), 32'd0);
    check_val("abort adrC hold", 32'(adrC), 32'd2);
    for (int i = 0; i < 6; i++) begin
      step();
      check_quiet($sformatf("post-abort c%0d", i));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_quiet("idle abort");
    check_val("idle abort adrC", 32'(adrC), 32'd2);

    run_burst(7'd2, 7'd1, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
